// File: rtl/pc_sequencer_if.sv
// Control/status bundle between a PC consumer (master) and the pc_sequencer (slave).
// The master drives the fetch-control requests; the sequencer returns PC and status.
interface pc_sequencer_if #(
  parameter int PC_WIDTH  = 5,
  parameter int CNT_WIDTH = 16
);
  logic                 start;
  logic [PC_WIDTH-1:0]  start_pc;
  logic                 stall;
  logic                 jump;
  logic [PC_WIDTH-1:0]  jump_target;
  logic                 branch_taken;
  logic [PC_WIDTH-1:0]  branch_offset;
  logic                 halt_req;
  logic [PC_WIDTH-1:0]  pc;
  logic                 pc_valid;
  logic                 halted;
  logic [CNT_WIDTH-1:0] retired;

  modport master (
    output start, start_pc, stall, jump, jump_target, branch_taken, branch_offset, halt_req,
    input  pc, pc_valid, halted, retired
  );

  modport slave (
    input  start, start_pc, stall, jump, jump_target, branch_taken, branch_offset, halt_req,
    output pc, pc_valid, halted, retired
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: linear fetch, jump/branch redirects, stall, halt,
// and a saturating retired-instruction counter. All outputs are registered.
module pc_sequencer #(
  parameter int PC_WIDTH  = 5,
  parameter int RESET_PC  = 0,
  parameter int CNT_WIDTH = 16,
  parameter bit WRAP      = 1'b1
) (
  input  logic           clk,
  input  logic           reset,
  pc_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  localparam logic [PC_WIDTH-1:0]  PC_ONE     = PC_WIDTH'(1);
  localparam logic [PC_WIDTH-1:0]  PC_MAX     = '1;
  localparam logic [PC_WIDTH-1:0]  RESET_PC_V = PC_WIDTH'(RESET_PC);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX    = '1;

  state_e               state_q, state_d;
  logic [PC_WIDTH-1:0]  pc_q, pc_d;
  logic [CNT_WIDTH-1:0] retired_q, retired_d;
  logic                 pc_valid_q, halted_q;
  logic [CNT_WIDTH-1:0] retired_inc;

  // The counter sticks at its maximum rather than rolling over.
  assign retired_inc = (retired_q == CNT_MAX) ? retired_q : retired_q + CNT_ONE;

  always_comb begin
    // NOTE: every next-state variable gets a default first so no path leaves it unassigned (no latch).
    state_d   = state_q;
    pc_d      = pc_q;
    retired_d = retired_q;

    unique case (state_q)
      ST_IDLE, ST_HALT: begin
        if (bus.start) begin
          state_d   = ST_RUN;
          pc_d      = bus.start_pc;
          retired_d = '0;
        end
      end
      ST_RUN: begin
        // halt_req outranks stall; a stalled cycle retires nothing and drops redirects.
        if (bus.halt_req) begin
          state_d   = ST_HALT;
          retired_d = retired_inc;
        end else if (!bus.stall) begin
          retired_d = retired_inc;
          if (bus.jump) begin
            pc_d = bus.jump_target;
          end else if (bus.branch_taken) begin
            pc_d = pc_q + PC_ONE + bus.branch_offset;
          end else if (!WRAP && (pc_q == PC_MAX)) begin
            state_d = ST_HALT;
          end else begin
            pc_d = pc_q + PC_ONE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (reset) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC_V;
      retired_q  <= '0;
      pc_valid_q <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      retired_q  <= retired_d;
      pc_valid_q <= (state_d == ST_RUN);
      halted_q   <= (state_d == ST_HALT);
    end
  end

  assign bus.pc       = pc_q;
  assign bus.pc_valid = pc_valid_q;
  assign bus.halted   = halted_q;
  assign bus.retired  = retired_q;

endmodule
